// File: rtl/uart_cmd.sv
// uart_cmd: line-oriented ASCII command interpreter between a byte UART and
// the board status outputs. Collects a short line, executes it on CR/LF,
// drives RGB/BLINK and streams a fixed-format reply through TX_OE/TX_RDY.
module uart_cmd #(
    parameter int BlinkDiv = 24_000_000
) (
    input  logic       CLK,
    input  logic       RST_,
    input  logic [7:0] RX_DATA,
    input  logic       RX_INT,
    input  logic       TX_RDY,
    output logic [7:0] TX_DATA,
    output logic       TX_OE,
    output logic [2:0] RGB,
    output logic       BLINK
);

    localparam int BW = $clog2(BlinkDiv);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BlinkDiv - 1);

    typedef enum logic [1:0] {COLLECT, EXEC, SEND, HOLD} state_t;
    typedef enum logic [1:0] {REP_OK, REP_ER, REP_STAT} reply_t;

    state_t        state;
    reply_t        reply;
    logic [2:0]    cnt;
    logic          ovf;
    logic [2:0]    idx;
    logic          en;
    logic [BW-1:0] blink_cnt;

    // Only the first two bytes can ever form a valid command; longer lines
    // are rejected by their length alone, so later bytes are only counted.
    logic [7:0]    line_buf [2];

    logic          rx_eol;
    logic          cmd_led;
    logic          cmd_blink;
    logic          cmd_stat;
    logic [2:0]    last_idx;

    assign rx_eol    = (RX_DATA == 8'h0D) || (RX_DATA == 8'h0A);
    assign cmd_led   = !ovf && (cnt == 3'd2) && (line_buf[0] == 8'h4C)
                       && (line_buf[1][7:3] == 5'b00110);
    assign cmd_blink = !ovf && (cnt == 3'd2) && (line_buf[0] == 8'h42)
                       && (line_buf[1][7:1] == 7'b0011000);
    assign cmd_stat  = !ovf && (cnt == 3'd1) && (line_buf[0] == 8'h3F);
    assign last_idx  = (reply == REP_STAT) ? 3'd5 : 3'd3;

    // Byte i of the selected reply; status digits come from the live RGB/en,
    // which cannot change while a reply is being sent.
    function automatic logic [7:0] reply_byte(input reply_t kind, input logic [2:0] i,
                                              input logic [2:0] rgb, input logic ena);
        logic [7:0] b;
        b = 8'h0A;
        case (kind)
            REP_OK: begin
                case (i)
                    3'd0:    b = 8'h4F;
                    3'd1:    b = 8'h4B;
                    3'd2:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
            REP_ER: begin
                case (i)
                    3'd0:    b = 8'h45;
                    3'd1:    b = 8'h52;
                    3'd2:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
            default: begin
                case (i)
                    3'd0:    b = 8'h4C;
                    3'd1:    b = {5'b00110, rgb};
                    3'd2:    b = 8'h42;
                    3'd3:    b = {7'b0011000, ena};
                    3'd4:    b = 8'h0D;
                    default: b = 8'h0A;
                endcase
            end
        endcase
        return b;
    endfunction

    // Line buffer capture: plain data, written only while collecting.
    always_ff @(posedge CLK) begin
        if (state == COLLECT && RX_INT && !rx_eol && cnt[2:1] == 2'b00)
            line_buf[cnt[0]] <= RX_DATA;
    end

    // Command FSM: collect, execute, then send each reply byte with a hold cycle.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state   <= COLLECT;
            reply   <= REP_OK;
            cnt     <= 3'd0;
            ovf     <= 1'b0;
            idx     <= 3'd0;
            en      <= 1'b0;
            RGB     <= 3'd0;
            TX_OE   <= 1'b0;
            TX_DATA <= 8'h00;
        end else begin
            case (state)
                COLLECT: begin
                    if (RX_INT) begin
                        if (rx_eol) begin
                            // Empty lines (including the LF of CRLF) are silent.
                            if (cnt != 3'd0 || ovf)
                                state <= EXEC;
                        end else if (cnt < 3'd4) begin
                            cnt <= cnt + 3'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cmd_led) begin
                        RGB   <= line_buf[1][2:0];
                        reply <= REP_OK;
                    end else if (cmd_blink) begin
                        en    <= line_buf[1][0];
                        reply <= REP_OK;
                    end else if (cmd_stat) begin
                        reply <= REP_STAT;
                    end else begin
                        reply <= REP_ER;
                    end
                    idx   <= 3'd0;
                    cnt   <= 3'd0;
                    ovf   <= 1'b0;
                    state <= SEND;
                end
                SEND: begin
                    if (TX_RDY) begin
                        TX_DATA <= reply_byte(reply, idx, RGB, en);
                        TX_OE   <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    TX_OE <= 1'b0;
                    idx   <= idx + 3'd1;
                    state <= (idx == last_idx) ? COLLECT : SEND;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Blink divider: free-runs only while enabled, otherwise parked at zero.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            blink_cnt <= '0;
            BLINK     <= 1'b0;
        end else if (!en) begin
            blink_cnt <= '0;
            BLINK     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            BLINK     <= ~BLINK;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_uart_cmd.sv
// tb_uart_cmd: directed scenarios plus randomized command lines for uart_cmd,
// checked every cycle against a queue-based behavioural model.
module tb_uart_cmd;

    localparam int BLINK_DIV = 4;

    logic       CLK;
    logic       RST_;
    logic [7:0] RX_DATA;
    logic       RX_INT;
    logic       TX_RDY;
    logic [7:0] TX_DATA;
    logic       TX_OE;
    logic [2:0] RGB;
    logic       BLINK;

    uart_cmd #(.BlinkDiv(BLINK_DIV)) dut (
        .CLK     (CLK),
        .RST_    (RST_),
        .RX_DATA (RX_DATA),
        .RX_INT  (RX_INT),
        .TX_RDY  (TX_RDY),
        .TX_DATA (TX_DATA),
        .TX_OE   (TX_OE),
        .RGB     (RGB),
        .BLINK   (BLINK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    bit         rnd_rdy  = 1'b0;

    // Behavioural model state
    logic [7:0] m_line[$];
    logic [7:0] m_rq[$];
    bit         m_ovf, m_exec, m_cool, m_en, m_blink, m_oe;
    int         m_bk;
    logic [2:0] m_rgb;
    logic [7:0] m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_line.delete();
        m_rq.delete();
        m_ovf = 0; m_exec = 0; m_cool = 0; m_en = 0; m_blink = 0; m_oe = 0;
        m_bk = 0; m_rgb = 3'd0; m_data = 8'h00;
    endtask

    task automatic push_reply(input logic [7:0] a, input logic [7:0] b);
        m_rq.push_back(a);
        m_rq.push_back(b);
        m_rq.push_back(8'h0D);
        m_rq.push_back(8'h0A);
    endtask

    // One clock edge of the model, using inputs and state as they were before the edge.
    task automatic model_step();
        logic [7:0] c0, c1;
        if (m_en) m_bk++;
        else m_bk = 0;
        m_blink = ((m_bk / BLINK_DIV) % 2) == 1;
        m_oe = 1'b0;
        if (m_exec) begin
            m_exec = 0;
            c0 = (m_line.size() > 0) ? m_line[0] : 8'h00;
            c1 = (m_line.size() > 1) ? m_line[1] : 8'h00;
            if (!m_ovf && m_line.size() == 2 && c0 == "L" && c1 >= "0" && c1 <= "7") begin
                m_rgb = 3'(c1 - 8'h30);
                push_reply("O", "K");
            end else if (!m_ovf && m_line.size() == 2 && c0 == "B" && (c1 == "0" || c1 == "1")) begin
                m_en = (c1 == "1");
                push_reply("O", "K");
            end else if (!m_ovf && m_line.size() == 1 && c0 == "?") begin
                m_rq.push_back("L");
                m_rq.push_back(8'h30 + {5'd0, m_rgb});
                push_reply("B", m_en ? 8'h31 : 8'h30);
            end else begin
                push_reply("E", "R");
            end
            m_line.delete();
            m_ovf = 0;
        end else if (m_cool) begin
            m_cool = 0;
        end else if (m_rq.size() != 0) begin
            if (TX_RDY) begin
                m_data = m_rq.pop_front();
                m_oe   = 1'b1;
                m_cool = 1;
            end
        end else if (RX_INT) begin
            if (RX_DATA == 8'h0D || RX_DATA == 8'h0A) begin
                if (m_line.size() != 0 || m_ovf) m_exec = 1;
            end else if (m_line.size() < 4) begin
                m_line.push_back(RX_DATA);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    // Model advance on each rising edge, comparison on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge CLK);
            if (!RST_) model_reset();
            else model_step();
            cyc++;
            @(negedge CLK);
            if (RST_) begin
                check("tx_oe",   32'(TX_OE),   32'(m_oe));
                check("tx_data", 32'(TX_DATA), 32'(m_data));
                check("rgb",     32'(RGB),     32'(m_rgb));
                check("blink",   32'(BLINK),   32'(m_blink));
                if (TX_OE) begin
                    tx_log.push_back(TX_DATA);
                    tx_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
        if (rnd_rdy) TX_RDY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (rnd_rdy) repeat ($urandom_range(0, 1)) tick();
        RX_DATA = b;
        RX_INT  = 1'b1;
        tick();
        RX_INT  = 1'b0;
    endtask

    task automatic send_line(input string s, output int term);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        send_byte(8'h0D);
        term = cyc;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((m_exec || m_cool || m_rq.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 32'(n < 400), 32'd1);
        tick();
    endtask

    task automatic wait_tx(input string name, input int target, input int bound);
        int n;
        n = 0;
        while (tx_log.size() < target && n < bound) begin
            tick();
            n++;
        end
        check({name, "_txwait"}, 32'(tx_log.size() >= target), 32'd1);
    endtask

    task automatic check_reply(input string name, input int base, input string exp);
        check({name, "_len"}, 32'(tx_log.size() - base), 32'(exp.len()));
        for (int i = 0; i < exp.len(); i++)
            if (base + i < tx_log.size())
                check({name, "_byte"}, {24'h0, tx_log[base + i]}, {24'h0, exp[i]});
    endtask

    // Directed scenarios followed by randomized lines.
    initial begin
        int term, base, toggles, kind;
        logic prev;
        RST_ = 1'b0; RX_INT = 1'b0; RX_DATA = 8'h00; TX_RDY = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_tx_oe",   32'(TX_OE),   32'd0);
        check("rst_tx_data", 32'(TX_DATA), 32'd0);
        check("rst_rgb",     32'(RGB),     32'd0);
        check("rst_blink",   32'(BLINK),   32'd0);
        RST_ = 1'b1;
        repeat (3) tick();

        // Set LED with exact reply timing
        base = tx_log.size();
        send_line("L5", term);
        check("l5_rgb_n", 32'(RGB), 32'd0);
        tick();
        check("l5_rgb_n1", 32'(RGB), 32'd5);
        wait_idle("l5");
        check_reply("l5", base, "OK\015\012");
        if (tx_cyc.size() >= base + 4) begin
            check("l5_first_oe", 32'(tx_cyc[base]), 32'(term + 2));
            check("l5_last_oe",  32'(tx_cyc[base + 3]), 32'(term + 8));
        end
        base = tx_log.size();
        send_byte(8'h0A);
        repeat (10) tick();
        check("lf_silent", 32'(tx_log.size()), 32'(base));

        // Blink enable, status, disable
        base = tx_log.size();
        send_line("B1", term);
        wait_idle("b1");
        check_reply("b1", base, "OK\015\012");
        toggles = 0;
        prev = BLINK;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (BLINK != prev) toggles++;
            prev = BLINK;
        end
        check("blink_toggles", 32'(toggles), 32'd4);
        base = tx_log.size();
        send_line("?", term);
        wait_idle("stat1");
        check_reply("stat1", base, "L5B1\015\012");
        base = tx_log.size();
        send_line("B0", term);
        wait_idle("b0");
        check_reply("b0", base, "OK\015\012");
        repeat (6) tick();
        check("blink_off", 32'(BLINK), 32'd0);

        // Errors and recovery
        base = tx_log.size();
        send_line("L8", term);
        wait_idle("l8");
        check_reply("l8", base, "ER\015\012");
        check("l8_rgb", 32'(RGB), 32'd5);
        base = tx_log.size();
        send_line("l3", term);
        wait_idle("lc");
        check_reply("lc", base, "ER\015\012");
        base = tx_log.size();
        send_line("LLLLLL", term);
        wait_idle("ovf");
        check_reply("ovf", base, "ER\015\012");
        base = tx_log.size();
        send_line("L1", term);
        wait_idle("l1");
        check_reply("l1", base, "OK\015\012");
        check("l1_rgb", 32'(RGB), 32'd1);

        // Backpressure: nothing goes out without TX_RDY, one byte per grant
        TX_RDY = 1'b0;
        base = tx_log.size();
        send_line("L3", term);
        repeat (50) tick();
        check("bp_hold", 32'(tx_log.size()), 32'(base));
        for (int i = 0; i < 4; i++) begin
            repeat (5) tick();
            check("bp_wait", 32'(tx_log.size()), 32'(base + i));
            TX_RDY = 1'b1;
            wait_tx("bp", base + i + 1, 20);
            TX_RDY = 1'b0;
        end
        TX_RDY = 1'b1;
        wait_idle("bp");
        check_reply("bp", base, "OK\015\012");
        check("bp_rgb", 32'(RGB), 32'd3);

        // Bytes arriving during a reply are dropped
        base = tx_log.size();
        send_line("?", term);
        send_line("L2", term);
        wait_idle("drop");
        repeat (10) tick();
        check_reply("drop", base, "L3B0\015\012");
        check("drop_rgb", 32'(RGB), 32'd3);

        // Asynchronous reset mid-blink and mid-reply
        send_line("B1", term);
        wait_idle("rb1");
        repeat (3) tick();
        base = tx_log.size();
        send_line("?", term);
        wait_tx("rst", base + 2, 20);
        #1 RST_ = 1'b0;
        #1;
        check("arst_tx_oe",   32'(TX_OE),   32'd0);
        check("arst_tx_data", 32'(TX_DATA), 32'd0);
        check("arst_rgb",     32'(RGB),     32'd0);
        check("arst_blink",   32'(BLINK),   32'd0);
        tick();
        tick();
        RST_ = 1'b1;
        repeat (10) tick();
        check("rst_no_tx", 32'(tx_log.size()), 32'(base + 2));
        base = tx_log.size();
        send_line("L4", term);
        wait_idle("l4");
        check_reply("l4", base, "OK\015\012");
        check("l4_rgb", 32'(RGB), 32'd4);

        // Randomized lines, random gaps and random TX_RDY
        rnd_rdy = 1'b1;
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin send_byte(8'h4C); send_byte(8'h30 + 8'($urandom_range(0, 9))); end
                1: begin send_byte(8'h42); send_byte(8'h30 + 8'($urandom_range(0, 2))); end
                2: send_byte(8'h3F);
                3: repeat ($urandom_range(1, 7)) send_byte(8'($urandom_range(0, 255)));
                4: ;
                default: begin send_byte(8'h6C); send_byte(8'h30 + 8'($urandom_range(0, 7))); end
            endcase
            send_byte(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
            if ($urandom_range(0, 2) == 0) wait_idle("rnd");
            else repeat ($urandom_range(0, 4)) tick();
        end
        wait_idle("rnd_end");
        rnd_rdy = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL timeout: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

endmodule
